// File: rtl/generic_fifo_env_fwft.sv
// First-word-fall-through FIFO: 1r1w RAM (bit-masked writes, registered read) feeding a
// 2-entry output stage, with synchronous flush and almost-full/almost-empty flags.
module generic_fifo_env_fwft #(
   parameter int DAT_WIDTH = 26,
   parameter int DEPTH     = 512,
   parameter int PTR_WIDTH = $clog2(DEPTH),
   parameter int AF_LEVEL  = DEPTH - 4,
   parameter int AE_LEVEL  = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 wr_op,
   input  logic [DAT_WIDTH-1:0] wr_data,
   input  logic [DAT_WIDTH-1:0] wr_mask,
   output logic                 full,
   output logic                 almost_full,
   output logic                 wr_full_err,
   input  logic                 rd_op,
   output logic [DAT_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 empty,
   output logic                 almost_empty,
   output logic                 rd_empty_err,
   output logic [PTR_WIDTH:0]   entry_used
);

   localparam int CNT_W = PTR_WIDTH + 1;

   logic [DAT_WIDTH-1:0] mem [DEPTH];
   logic [DAT_WIDTH-1:0] ram_dout;

   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     ram_cnt_q, ram_cnt_d;
   logic [CNT_W-1:0]     entry_used_q, entry_used_d;
   logic                 rd_busy_q, rd_busy_d;
   logic [1:0]           stg_cnt_q, stg_cnt_d;
   logic [DAT_WIDTH-1:0] stg0_q, stg0_d;
   logic [DAT_WIDTH-1:0] stg1_q, stg1_d;
   logic                 full_q, full_d;
   logic                 af_q, af_d;
   logic                 ae_q, ae_d;
   logic                 wr_err_q, wr_err_d;
   logic                 rd_err_q, rd_err_d;

   logic                 push;
   logic                 pop;
   logic                 ram_rd;
   logic [2:0]           stg_claim;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   assign push = wr_op & ~full_q & ~clr;
   assign pop  = rd_op & (stg_cnt_q != 2'd0) & ~clr;

   // Stage slots already committed after this cycle's pop, counting the read in flight.
   assign stg_claim = {1'b0, stg_cnt_q} + {2'b00, rd_busy_q} - {2'b00, pop};
   assign ram_rd    = ~clr & (ram_cnt_q != '0) & (stg_claim < 3'd2);

   // RAM is never reset; only bits selected by wr_mask are updated.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = 0; i < DAT_WIDTH; i++) begin
            if (wr_mask[i]) begin
               mem[wr_ptr_q][i] <= wr_data[i];
            end
         end
      end
      if (ram_rd) begin
         ram_dout <= mem[rd_ptr_q];
      end
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      ram_cnt_d    = ram_cnt_q;
      entry_used_d = entry_used_q;
      rd_busy_d    = 1'b0;
      stg_cnt_d    = stg_cnt_q;
      stg0_d       = stg0_q;
      stg1_d       = stg1_q;
      if (clr) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         ram_cnt_d    = '0;
         entry_used_d = '0;
         stg_cnt_d    = 2'd0;
      end else begin
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (ram_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         ram_cnt_d    = ram_cnt_q + CNT_W'(push) - CNT_W'(ram_rd);
         entry_used_d = entry_used_q + CNT_W'(push) - CNT_W'(pop);
         rd_busy_d    = ram_rd;
         if (pop) begin
            stg0_d    = stg1_q;
            stg_cnt_d = stg_cnt_q - 2'd1;
         end
         // Landing word goes into the first free slot left after the pop.
         if (rd_busy_q) begin
            if (stg_cnt_d == 2'd0) begin
               stg0_d = ram_dout;
            end else begin
               stg1_d = ram_dout;
            end
            stg_cnt_d = stg_cnt_d + 2'd1;
         end
      end
      full_d   = (entry_used_d == CNT_W'(DEPTH));
      af_d     = (entry_used_d >= CNT_W'(AF_LEVEL));
      ae_d     = (entry_used_d <= CNT_W'(AE_LEVEL));
      wr_err_d = wr_op & full_q & ~clr;
      rd_err_d = rd_op & (stg_cnt_q == 2'd0) & ~clr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ram_cnt_q    <= '0;
         entry_used_q <= '0;
         rd_busy_q    <= 1'b0;
         stg_cnt_q    <= 2'd0;
         stg0_q       <= '0;
         stg1_q       <= '0;
         full_q       <= 1'b0;
         af_q         <= 1'b0;
         ae_q         <= 1'b1;
         wr_err_q     <= 1'b0;
         rd_err_q     <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ram_cnt_q    <= ram_cnt_d;
         entry_used_q <= entry_used_d;
         rd_busy_q    <= rd_busy_d;
         stg_cnt_q    <= stg_cnt_d;
         stg0_q       <= stg0_d;
         stg1_q       <= stg1_d;
         full_q       <= full_d;
         af_q         <= af_d;
         ae_q         <= ae_d;
         wr_err_q     <= wr_err_d;
         rd_err_q     <= rd_err_d;
      end
   end

   assign rd_data      = stg0_q;
   assign rd_valid     = (stg_cnt_q != 2'd0);
   assign empty        = (stg_cnt_q == 2'd0);
   assign full         = full_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign wr_full_err  = wr_err_q;
   assign rd_empty_err = rd_err_q;
   assign entry_used   = entry_used_q;

endmodule

// File: tb/tb_generic_fifo_env_fwft.sv
// Randomised bench for generic_fifo_env_fwft: a queue-based reference model tracks
// contents, visibility latency and flags; a negedge monitor compares and pops.
module tb_generic_fifo_env_fwft;

   localparam int DW    = 26;
   localparam int DEPTH = 512;
   localparam int AF    = DEPTH - 4;
   localparam int AE    = 2;
   localparam int PW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clr;
   logic          wr_op;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] wr_mask;
   logic          full;
   logic          almost_full;
   logic          wr_full_err;
   logic          rd_op;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          empty;
   logic          almost_empty;
   logic          rd_empty_err;
   logic [PW:0]   entry_used;

   generic_fifo_env_fwft #(
      .DAT_WIDTH(DW),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr         (clr),
      .wr_op       (wr_op),
      .wr_data     (wr_data),
      .wr_mask     (wr_mask),
      .full        (full),
      .almost_full (almost_full),
      .wr_full_err (wr_full_err),
      .rd_op       (rd_op),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .empty       (empty),
      .almost_empty(almost_empty),
      .rd_empty_err(rd_empty_err),
      .entry_used  (entry_used)
   );

   always #5 clk = ~clk;

   // Reference model: RAM image with per-bit "written" tracking, plus an ordered
   // queue of pushed words tagged with the clock edge at which they were accepted.
   typedef struct {
      logic [DW-1:0] d;
      logic [DW-1:0] k;
      int            age;
   } ent_t;

   logic [DW-1:0] mmem   [DEPTH];
   logic [DW-1:0] mknown [DEPTH];
   ent_t          mq [$];
   int            mwr;
   int            cyc;
   bit            e_werr;
   bit            e_rderr;
   int            checks   = 0;
   int            failures = 0;
   int            pops_seen = 0;

   function automatic void chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, cyc, $time);
      end
   endfunction

   always @(negedge clk) begin
      int   n;
      bit   mvalid;
      ent_t e;
      if (!reset_n) begin
         mq.delete();
         mwr     = 0;
         cyc     = 0;
         e_werr  = 1'b0;
         e_rderr = 1'b0;
         for (int i = 0; i < DEPTH; i++) mknown[i] = '0;
         chk("rst_rd_data", rd_data, 0);
         chk("rst_rd_valid", rd_valid, 0);
         chk("rst_empty", empty, 1);
         chk("rst_full", full, 0);
         chk("rst_almost_full", almost_full, 0);
         chk("rst_almost_empty", almost_empty, 1);
         chk("rst_errs", {wr_full_err, rd_empty_err}, 0);
         chk("rst_entry_used", entry_used, 0);
      end else begin
         n      = mq.size();
         // A word becomes visible two edges after it was accepted (write, then RAM read).
         mvalid = (n > 0) && ((cyc - mq[0].age) >= 2);
         chk("entry_used", entry_used, n);
         chk("full", full, (n == DEPTH));
         chk("almost_full", almost_full, (n >= AF));
         chk("almost_empty", almost_empty, (n <= AE));
         chk("rd_valid", rd_valid, mvalid);
         chk("empty", empty, !mvalid);
         chk("wr_full_err", wr_full_err, e_werr);
         chk("rd_empty_err", rd_empty_err, e_rderr);
         e_werr  = wr_op && !clr && (n == DEPTH);
         e_rderr = rd_op && !clr && !mvalid;
         if (clr) begin
            mq.delete();
            mwr = 0;
         end else begin
            if (rd_op && mvalid) begin
               e = mq.pop_front();
               chk("rd_data", rd_data & e.k, e.d & e.k);
               pops_seen++;
            end
            if (wr_op && (n < DEPTH)) begin
               mmem[mwr]   = (mmem[mwr] & ~wr_mask) | (wr_data & wr_mask);
               mknown[mwr] = mknown[mwr] | wr_mask;
               e.d   = mmem[mwr];
               e.k   = mknown[mwr];
               e.age = cyc + 1;
               mq.push_back(e);
               mwr = (mwr + 1) % DEPTH;
            end
         end
         cyc++;
      end
   end

   localparam logic [DW-1:0] ALL = '1;

   task automatic drive(input bit w, input logic [DW-1:0] d, input logic [DW-1:0] m,
                        input bit r, input bit c);
      wr_op   = w;
      wr_data = d;
      wr_mask = m;
      rd_op   = r;
      clr     = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, ALL, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      clr     = 1'b0;
      wr_op   = 1'b0;
      rd_op   = 1'b0;
      wr_data = '0;
      wr_mask = ALL;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(2);

      $display("phase T1: three pushes then back-to-back pops");
      drive(1'b1, 26'h1, ALL, 1'b0, 1'b0);
      drive(1'b1, 26'h2, ALL, 1'b0, 1'b0);
      drive(1'b1, 26'h3, ALL, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, ALL, 1'b1, 1'b0);
      idle(2);

      $display("phase T3: pop while empty");
      drive(1'b0, '0, ALL, 1'b1, 1'b0);
      idle(3);

      $display("phase T2/T5: fill to full, push+pop while full, drain");
      for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'($urandom), ALL, 1'b0, 1'b0);
      idle(2);
      drive(1'b1, DW'($urandom), ALL, 1'b1, 1'b0);
      idle(2);
      for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, '0, ALL, 1'b1, 1'b0);
      idle(2);

      $display("phase T4: streaming push and pop every cycle");
      for (int i = 0; i < 2000; i++) drive(1'b1, DW'($urandom), ALL, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, ALL, 1'b1, 1'b0);
      idle(2);

      $display("phase T6: masked overwrite of a previously written address");
      drive(1'b0, '0, ALL, 1'b0, 1'b1);
      drive(1'b1, 26'h3FFFFFF, ALL, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, '0, ALL, 1'b1, 1'b0);
      drive(1'b0, '0, ALL, 1'b0, 1'b1);
      drive(1'b1, 26'h0, 26'h00000FF, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, '0, ALL, 1'b1, 1'b0);
      idle(1);

      $display("phase flush mid-stream");
      for (int i = 0; i < 20; i++) drive(1'b1, DW'($urandom), ALL, (i > 10), 1'b0);
      drive(1'b1, DW'($urandom), ALL, 1'b1, 1'b1);
      idle(3);

      $display("phase random traffic with masks and flushes");
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) != 0), DW'($urandom),
               ($urandom_range(0, 1) != 0) ? ALL : DW'($urandom),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
      end
      for (int i = 0; i < 600; i++) drive(($urandom_range(0, 1) != 0), DW'($urandom), ALL, 1'b0, 1'b0);
      for (int i = 0; i < 700; i++) drive(1'b0, '0, ALL, 1'b1, 1'b0);

      $display("phase async reset mid-burst");
      for (int i = 0; i < 6; i++) drive(1'b1, DW'($urandom), ALL, (i > 3), 1'b0);
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(1);
      drive(1'b1, 26'h155, ALL, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, '0, ALL, 1'b1, 1'b0);
      idle(3);

      checks++;
      if (pops_seen < 3000) begin
         failures++;
         $display("FAIL pop_count: got %0d expected at least 3000", pops_seen);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
